// File: rtl/ma_stage.sv
// Memory-access pipeline stage: waits out the data-SRAM read latency and holds load data
// across WB back-pressure. Optional stall/load counters are enabled by defining MA_STALL_CNT_EN.
module ma_stage #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_validout,
    input  logic        wb_allowin,
    output logic        ma_allowin,
    output logic        ma_validout,
    input  logic [70:0] ex_to_ma_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] ma_to_wb_bus,
    output logic [5:0]  ma_fwd_bus
`ifdef MA_STALL_CNT_EN
    ,
    output logic [31:0] ma_stall_cnt,
    output logic [31:0] ma_load_cnt
`endif
);

    localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

    logic        valid_q, valid_d;
    logic [70:0] bus_q, bus_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        hold_q, hold_d;
    logic [31:0] hold_data_q, hold_data_d;

    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] final_result;
    logic        readygo;
    logic        rdata_cycle;
    logic        accept;

    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    // The SRAM returns data only in the cycle where the counter reaches RD_LAT-1.
    assign rdata_cycle = valid_q & res_from_mem & ~hold_q & (cnt_q == LastCnt);
    assign readygo     = ~res_from_mem | hold_q | (cnt_q == LastCnt);
    assign ma_validout = valid_q & readygo;
    assign ma_allowin  = ~valid_q | (readygo & wb_allowin);
    assign accept      = ex_validout & ma_allowin;

    assign final_result = res_from_mem ? (hold_q ? hold_data_q : data_sram_rdata) : alu_result;
    assign ma_to_wb_bus = {gr_we, dest, final_result, pc};
    assign ma_fwd_bus   = {valid_q & gr_we, (valid_q & gr_we) ? dest : 5'd0};

    always_comb begin
        valid_d     = valid_q;
        bus_d       = bus_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_data_d = hold_data_q;
        if (ma_allowin) begin
            valid_d = ex_validout;
        end
        // A new entry takes precedence over any progress of the departing instruction.
        if (accept) begin
            bus_d  = ex_to_ma_bus;
            cnt_d  = 2'd0;
            hold_d = 1'b0;
        end else begin
            if (valid_q && res_from_mem && !hold_q && (cnt_q < LastCnt)) begin
                cnt_d = cnt_q + 2'd1;
            end
            if (rdata_cycle && !wb_allowin) begin
                hold_d      = 1'b1;
                hold_data_d = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            bus_q       <= '0;
            cnt_q       <= 2'd0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            valid_q     <= valid_d;
            bus_q       <= bus_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
        end
    end

`ifdef MA_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] load_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            if (valid_q && !(readygo && wb_allowin) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ma_validout && wb_allowin && res_from_mem && (load_cnt_q != 32'hFFFF_FFFF)) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
        end
    end

    assign ma_stall_cnt = stall_cnt_q;
    assign ma_load_cnt  = load_cnt_q;
`endif

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Accepts the 71-bit EX→MA bus through a valid/allowin handshake and waits the data-SRAM read latency for loads.
- Captures load data into a hold register so it survives WB back-pressure, selects ALU result or load data, and drives the 70-bit MA→WB bus.
- Also exports a 6-bit destination/bypass bus for ID-stage hazard detection.

Parameters:
- RD_LAT, default 1: data-SRAM read latency in cycles, counted from the EX-stage request. Legal values 1..3.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low (rst==0 at posedge resets).
- ex_validout  in  1  EX holds a valid instruction ready to pass.
- wb_allowin  in  1  WB can accept this cycle.
- ma_allowin  out  1  MA can accept this cycle.
- ma_validout  out  1  MA output valid and ready to pass to WB.
- ex_to_ma_bus  in  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- data_sram_rdata  in  32  synchronous SRAM read data.
- ma_to_wb_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- ma_fwd_bus  out  6  {valid & gr_we, dest}; dest is forced to 0 when bit 5 is 0.

Behaviour:
- Reset (rst==0 at posedge):
  - valid=0, bus register=0, wait counter=0, hold flag=0, hold data=0.
  - Outputs then read: ma_validout=0, ma_allowin=1, ma_fwd_bus=0, ma_to_wb_bus=0.
  - Reset mid-load discards the instruction; no WB transfer occurs.
- Handshake:
  - ma_allowin = ~valid | (readygo & wb_allowin).
  - ma_validout = valid & readygo.
  - On posedge with ma_allowin: valid <= ex_validout.
  - If ex_validout & ma_allowin: bus register <= ex_to_ma_bus, wait counter <= 0, hold flag <= 0.
- Entry cycle: the first cycle an instruction resides in MA is cycle 1.
- Load timing: data_sram_rdata for a load is valid only in MA cycle RD_LAT. It is undefined in all other cycles.
- Wait counter:
  - 2 bits.
  - Increments each cycle while valid & res_from_mem & ~hold & (counter < RD_LAT-1).
  - Saturates at RD_LAT-1.
- readygo:
  - Non-load (res_from_mem==0): 1 in cycle 1.
  - Load: 1 when hold==1, or when counter==RD_LAT-1 (the rdata-valid cycle).
  - With RD_LAT=1, every instruction passes in 1 cycle when wb_allowin=1.
- Hold buffer:
  - Condition: in the rdata-valid cycle of a load, if wb_allowin==0.
  - Action: hold data <= data_sram_rdata, hold flag <= 1.
  - Once hold==1, the buffered value is used and data_sram_rdata is ignored until the instruction leaves.
- final_result:
  - res_from_mem ? (hold ? hold_data : data_sram_rdata) : alu_result.
  - Full 32-bit; no sign or zero extension.
- Simultaneous leave and enter:
  - Old instruction leaves and a new one enters in the same posedge.
  - New entry wins: counter and hold flag clear, no bubble.
- Bubble: when valid=0, the bus register is retained, but ma_validout=0 and ma_fwd_bus=0.
- Stall with no hold needed: a non-load, or a load already holding, stays stable on ma_to_wb_bus while wb_allowin=0. Bus bits do not change.

Optional Feature:
- Macro: MA_STALL_CNT_EN.
- When defined:
  - Adds output ma_stall_cnt (out, 32): counts cycles where valid & ~(readygo & wb_allowin).
  - Saturates at 0xFFFFFFFF; reset to 0 by rst==0.
  - Adds output ma_load_cnt (out, 32): counts loads passed to WB (ma_validout & wb_allowin & res_from_mem); saturating.
- When undefined: neither port exists, no counter logic is present, and all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: rst=0 for 2 cycles with ex_validout=1.
  - Response: ma_validout=0, ma_allowin=1, ma_fwd_bus=0; after rst=1, first posedge with ex_validout=1 loads the bus.
- ALU pass-through, RD_LAT=1:
  - Stimulus: bus {0,1,5'd3,32'h1234_5678,32'h1C00_0000}, wb_allowin=1.
  - Response: next cycle ma_validout=1, ma_to_wb_bus={1,3,32'h1234_5678,32'h1C00_0000}, ma_fwd_bus=6'b1_00011.
- Load with WB stall, RD_LAT=1:
  - Stimulus: load enters, rdata=32'hDEAD_BEEF in cycle 1, wb_allowin=0 for 3 cycles, rdata driven to 32'h0.
  - Response: final_result stays 32'hDEAD_BEEF throughout; transfer occurs when wb_allowin=1.
- Latency, RD_LAT=3:
  - Stimulus: load enters, wb_allowin=1.
  - Response: ma_validout=0 in cycles 1-2, 1 in cycle 3 with rdata from cycle 3; ma_allowin=0 in cycles 1-2.
- Back-to-back with reset mid-operation:
  - Stimulus: three non-loads streamed with wb_allowin=1 → one transfer per cycle, no bubbles.
  - Stimulus: then a load with RD_LAT=2 and rst=0 in cycle 1.
  - Response: valid=0 next cycle, no WB transfer.
- MA_STALL_CNT_EN:
  - Stimulus: 2-cycle WB stall on a load, then transfer.
  - Response: ma_stall_cnt=2, ma_load_cnt=1.
